norm288: RTL and testbench

Pipelined left-justifying normalizer for 288-bit significands. It sits directly downstream of the 288-bit find-last-one detector and consumes that detector's 9-bit leading-one index (511 = no bit set). It shifts the significand so its leading one lands at bit 287 and adjusts the exponent to match. It is an elastic 3-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/norm288_pkg.sv | 27 ++
 rtl/norm288_shift.sv | 70 +++++++
 rtl/norm288.sv | 141 ++++++++++++++
 tb/tb_norm288.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm288_pkg.sv
// norm288_pkg: shared widths, constants and the stage payload type for the
// norm288 left-justifying normalizer.
package norm288_pkg;

    parameter int EXPW = 20;

    localparam int MANW  = 288;
    localparam int LEADW = 9;

    localparam logic [LEADW-1:0] LEAD_NONE = 9'd511;
    localparam logic [LEADW-1:0] LEAD_TOP  = 9'd287;

    // Payload carried from S1 through S3.
    typedef struct packed {
        logic [MANW-1:0]  man;
        logic [EXPW-1:0]  exp;
        logic [LEADW-1:0] shift_eff;
        logic             zero;
        logic             under;
    } norm_stage_t;

    // A leading-one index outside the significand means "no bit set".
    function automatic logic lead_is_zero(input logic [LEADW-1:0] lead);
        return (lead == LEAD_NONE) || (lead > LEAD_TOP);
    endfunction

endpackage

// File: rtl/norm288_shift.sv
// norm288_shift: one elastic pipeline stage that shifts the significand left
// by (selected shift_eff field) * STEP and registers the result.
module norm288_shift
    import norm288_pkg::*;
#(
    parameter int STEP    = 16,
    parameter int SELW    = 5,
    parameter int SEL_LSB = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  norm_stage_t in_stage_i,
    input  logic        ready_i,
    output logic        en_o,
    output logic        valid_o,
    output norm_stage_t stage_o
);

    logic        v_q;
    logic        v_d;
    norm_stage_t stage_q;
    norm_stage_t stage_d;
    norm_stage_t shifted_s;
    logic [SELW-1:0] sel_s;
    logic [9:0]      amt_s;

    // The stage may load when it is empty or its content is leaving.
    assign en_o    = !v_q || ready_i;
    assign valid_o = v_q;
    assign stage_o = stage_q;

    assign sel_s = in_stage_i.shift_eff[SEL_LSB +: SELW];
    assign amt_s = 10'(sel_s) * 10'(STEP);

    // Shift the incoming significand; all other fields pass through.
    always_comb begin
        shifted_s     = in_stage_i;
        shifted_s.man = in_stage_i.man << amt_s;
    end

    // Next-state: load on enable, otherwise hold so outputs stay stable.
    always_comb begin
        v_d     = v_q;
        stage_d = stage_q;
        if (en_o) begin
            v_d = in_valid_i;
            if (in_valid_i) begin
                stage_d = shifted_s;
            end else begin
                stage_d = stage_q;
            end
        end else begin
            v_d     = v_q;
            stage_d = stage_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q     <= 1'b0;
            stage_q <= '0;
        end else begin
            v_q     <= v_d;
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/norm288.sv
// norm288: 3-stage elastic left-justifying normalizer for 288-bit
// significands. S1 decodes the leading-one index, S2 does the coarse
// (16-bit granular) shift, S3 the fine shift and drives the outputs.
// Build option: define NORM288_DENORM_EN for gradual underflow; otherwise
// underflowing results are flushed to zero.
module norm288
    import norm288_pkg::*;
#(
    parameter int EXPW = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [MANW-1:0]  man_i,
    input  logic [EXPW-1:0]  exp_i,
    input  logic [LEADW-1:0] lead_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [MANW-1:0]  man_o,
    output logic [EXPW-1:0]  exp_o,
    output logic             zero_o,
    output logic             under_o
);

    logic [LEADW-1:0] shift_s;
    logic [EXPW:0]    diff_s;
    logic             zero_s;
    logic             under_s;
    norm_stage_t      dec_s;

    logic        v1_q;
    logic        v1_d;
    norm_stage_t s1_q;
    norm_stage_t s1_d;
    logic        en1_s;
    logic        en2_s;
    logic        en3_s;
    logic        v2_s;
    norm_stage_t s2_s;
    logic        v3_s;
    norm_stage_t s3_s;
    logic        unused_shift_s;

    assign shift_s = LEAD_TOP - lead_i;
    assign zero_s  = lead_is_zero(lead_i);
    assign diff_s  = {1'b0, exp_i} - (EXPW+1)'(shift_s);
    assign under_s = !zero_s && diff_s[EXPW];

    // S1 decode: classify the beat and choose the effective shift.
    always_comb begin
        dec_s.man       = man_i;
        dec_s.exp       = diff_s[EXPW-1:0];
        dec_s.shift_eff = shift_s;
        dec_s.zero      = 1'b0;
        dec_s.under     = 1'b0;
        if (zero_s) begin
            dec_s.man       = '0;
            dec_s.exp       = '0;
            dec_s.shift_eff = '0;
            dec_s.zero      = 1'b1;
            dec_s.under     = 1'b0;
        end else if (under_s) begin
`ifdef NORM288_DENORM_EN
            // Shift only as far as the exponent allows (exp_i < 287 here).
            dec_s.shift_eff = exp_i[LEADW-1:0];
            dec_s.exp       = '0;
            dec_s.under     = 1'b1;
`else
            dec_s.man   = '0;
            dec_s.exp   = '0;
            dec_s.zero  = 1'b1;
            dec_s.under = 1'b1;
`endif
        end else begin
            dec_s.under = 1'b0;
        end
    end

    // Upstream ready ripples back from out_ready_i through every stage.
    assign en1_s      = !v1_q || en2_s;
    assign in_ready_o = en1_s;

    // S1 next-state: load a decoded beat when enabled, otherwise hold.
    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        if (en1_s) begin
            v1_d = in_valid_i;
            if (in_valid_i) begin
                s1_d = dec_s;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            v1_d = v1_q;
            s1_d = s1_q;
        end
    end

    // S1 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else begin
            v1_q <= v1_d;
            s1_q <= s1_d;
        end
    end

    norm288_shift #(.STEP(16), .SELW(5), .SEL_LSB(4)) u_s2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (v1_q),
        .in_stage_i (s1_q),
        .ready_i    (en3_s),
        .en_o       (en2_s),
        .valid_o    (v2_s),
        .stage_o    (s2_s)
    );

    norm288_shift #(.STEP(1), .SELW(4), .SEL_LSB(0)) u_s3 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (v2_s),
        .in_stage_i (s2_s),
        .ready_i    (out_ready_i),
        .en_o       (en3_s),
        .valid_o    (v3_s),
        .stage_o    (s3_s)
    );

    assign out_valid_o    = v3_s;
    assign man_o          = s3_s.man;
    assign exp_o          = s3_s.exp;
    assign zero_o         = s3_s.zero;
    assign under_o        = s3_s.under;
    assign unused_shift_s = ^s3_s.shift_eff;

endmodule

// File: tb/tb_norm288.sv
// tb_norm288: directed and randomized checks of norm288 against a
// behavioural model of the normalization rules.
module tb_norm288;

    localparam int EXPW = 20;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [287:0]     man_i;
    logic [EXPW-1:0]  exp_i;
    logic [8:0]       lead_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [287:0]     man_o;
    logic [EXPW-1:0]  exp_o;
    logic             zero_o;
    logic             under_o;

    norm288 #(.EXPW(EXPW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .man_i       (man_i),
        .exp_i       (exp_i),
        .lead_i      (lead_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .man_o       (man_o),
        .exp_o       (exp_o),
        .zero_o      (zero_o),
        .under_o     (under_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [287:0]    man;
        logic [EXPW-1:0] exp;
        logic            zero;
        logic            under;
    } res_t;

    res_t q[$];
    int   acc_cyc_q[$];
    res_t out_log[$];
    int   cyc = 0;
    int   last_lat = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   acc_f = 1'b0;
    bit   rdy_seen = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference: left-justify by plain arithmetic on the leading-one index.
    function automatic res_t ref_norm(logic [287:0] m, logic [EXPW-1:0] e, logic [8:0] l);
        res_t r;
        int   sh;
        r.man = '0; r.exp = '0; r.zero = 1'b1; r.under = 1'b0;
        if (int'(l) <= 287) begin
            sh = 287 - int'(l);
            if (int'(e) >= sh) begin
                r.man  = m << sh;
                r.exp  = e - EXPW'(sh);
                r.zero = 1'b0;
            end else begin
`ifdef NORM288_DENORM_EN
                r.man   = m << e;
                r.zero  = 1'b0;
                r.under = 1'b1;
`else
                r.under = 1'b1;
`endif
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge, update model, then move past the posedge.
    task automatic step();
        res_t e;
        @(negedge clk_i);
        cyc++;
        rdy_seen = in_ready_o;
        if (out_valid_o) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 288'(out_valid_o), 288'(0));
            end else begin
                e = q[0];
                chk("man", man_o, e.man);
                chk("exp", 288'(exp_o), 288'(e.exp));
                chk("zero", 288'(zero_o), 288'(e.zero));
                chk("under", 288'(under_o), 288'(e.under));
                if (out_ready_i) begin
                    void'(q.pop_front());
                    last_lat = cyc - acc_cyc_q.pop_front();
                    out_log.push_back(e);
                    n_out++;
                end
            end
        end
        acc_f = in_valid_i && in_ready_o;
        if (acc_f) begin
            q.push_back(ref_norm(man_i, exp_i, lead_i));
            acc_cyc_q.push_back(cyc);
            n_acc++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string tag);
        out_ready_i = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        chk(tag, 288'(q.size()), 288'(0));
    endtask

    task automatic send_one(input logic [287:0] m, input logic [EXPW-1:0] e, input logic [8:0] l);
        man_i = m; exp_i = e; lead_i = l; in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc_f) break;
        end
        in_valid_i = 1'b0;
        out_log.delete();
        drain("drain_timeout");
    endtask

    task automatic rand_beat();
        logic [287:0] m;
        logic [287:0] one;
        int           k;
        for (int w = 0; w < 9; w++) m[w*32 +: 32] = $urandom;
        one = 288'(1);
        k = $urandom_range(0, 9);
        if (k == 0) begin
            lead_i = 9'd511; m = '0;
        end else if (k == 1) begin
            lead_i = 9'($urandom_range(288, 510));
        end else begin
            lead_i = 9'($urandom_range(0, 287));
            m = (m & ((one << lead_i) - 288'(1))) | (one << lead_i);
        end
        man_i = m;
        exp_i = ($urandom_range(0, 3) == 0) ? EXPW'($urandom) : EXPW'($urandom_range(0, 600));
    endtask

    initial begin
        res_t         r;
        int           idx;
        int           acc0;
        logic [287:0] one;
        logic [287:0] m;
        one = 288'(1);

        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        man_i = '0; exp_i = '0; lead_i = 9'd511;
        #12;
        chk("rst_out_valid", 288'(out_valid_o), 288'(0));
        chk("rst_man", man_o, 288'(0));
        chk("rst_exp", 288'(exp_o), 288'(0));
        chk("rst_zero", 288'(zero_o), 288'(0));
        chk("rst_under", 288'(under_o), 288'(0));
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_in_ready", 288'(in_ready_o), 288'(1));

        // Normal case.
        send_one(288'(1), EXPW'(1000), 9'd0);
        chk("t1_lat", 288'(last_lat), 288'(3));
        r = out_log[0];
        chk("t1_man", r.man, one << 287);
        chk("t1_exp", 288'(r.exp), 288'(713));
        chk("t1_flags", 288'({r.zero, r.under}), 288'(0));

        // Zero cases.
        send_one(288'(0), EXPW'(500), 9'd511);
        r = out_log[0];
        chk("t2_man", r.man, 288'(0));
        chk("t2_bits", 288'({r.exp, r.zero, r.under}), 288'(2));
        send_one(288'(0), EXPW'(500), 9'd300);
        r = out_log[0];
        chk("t2b_man", r.man, 288'(0));
        chk("t2b_bits", 288'({r.exp, r.zero, r.under}), 288'(2));

        // Underflow.
        send_one(288'(1), EXPW'(100), 9'd0);
        r = out_log[0];
`ifdef NORM288_DENORM_EN
        chk("t3_man", r.man, one << 100);
        chk("t3_bits", 288'({r.exp, r.zero, r.under}), 288'(1));
`else
        chk("t3_man", r.man, 288'(0));
        chk("t3_bits", 288'({r.exp, r.zero, r.under}), 288'(3));
`endif

        // Back-to-back beats with a stalled sink.
        out_log.delete();
        idx = 0; acc0 = n_acc;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            m[287:0] = {9{$urandom}};
            lead_i = 9'(287 - idx);
            man_i = (m & ((one << lead_i) - 288'(1))) | (one << lead_i);
            exp_i = EXPW'(50); in_valid_i = 1'b1;
            out_ready_i = (c >= 5);
            step();
            if (c == 3) begin
                chk("bp_in_ready", 288'(rdy_seen), 288'(0));
                chk("bp_accepts", 288'(n_acc - acc0), 288'(3));
            end
            if (acc_f) idx++;
        end
        in_valid_i = 1'b0;
        drain("bp_drain");
        chk("bp_count", 288'(out_log.size()), 288'(6));
        for (int k = 0; k < out_log.size(); k++) begin
            r = out_log[k];
            chk("bp_exp_order", 288'(r.exp), 288'(50 - k));
            chk("bp_msb", 288'(r.man[287]), 288'(1));
        end

        // Full-throughput burst.
        acc0 = n_acc; out_ready_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rand_beat(); in_valid_i = 1'b1; step();
        end
        in_valid_i = 1'b0;
        chk("burst_accepts", 288'(n_acc - acc0), 288'(50));
        drain("burst_drain");

        // Random stream with random back-pressure.
        acc_f = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid_i || acc_f) begin
                if ($urandom_range(0, 9) < 8) begin
                    rand_beat(); in_valid_i = 1'b1;
                end else begin
                    in_valid_i = 1'b0;
                end
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid_i = 1'b0;
        drain("rand_drain");
        chk("rand_conserved", 288'(n_out), 288'(n_acc));

        // Reset with beats in flight.
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_beat(); lead_i = 9'd287; man_i[287] = 1'b1; exp_i = EXPW'(400);
            in_valid_i = 1'b1; step();
        end
        in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 288'(out_valid_o), 288'(0));
        q.delete(); acc_cyc_q.delete();
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) step();
        send_one(288'(3), EXPW'(900), 9'd1);
        chk("post_rst_lat", 288'(last_lat), 288'(3));
        r = out_log[0];
        chk("post_rst_man", r.man, 288'(3) << 286);
        chk("post_rst_exp", 288'(r.exp), 288'(614));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
